// File: rtl/dmem_port.sv
// Data memory responder for the EX->WB stage: word array, RMW sub-word stores.
// Optional misalignment/illegal-request trapping under `DMEM_ALIGN_CHECK_EN.
module dmem_port #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic {IDLE, RMW} state_t;

    logic [31:0] mem [2**ADDR_WIDTH];

    state_t                state_q;
    logic                  stall_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic [ADDR_WIDTH-1:0] widx_q;
    logic [1:0]            lane_q;
    logic                  half_q;
    logic [31:0]           wdata_q;
    logic [31:0]           hold_q;

    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            lane;
    logic                  is_sub;
    logic                  bad;
    logic                  acc;
    logic                  do_load;
    logic                  do_wst;
    logic                  do_sst;
    logic [31:0]           rd_word;
    logic [31:0]           shifted;
    logic [31:0]           load_d;
    logic [31:0]           merged_d;
    logic                  unused_addr;

    assign widx        = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
    assign is_sub      = (size == 2'd0) || (size == 2'd1);
    assign acc         = req_valid & ~stall_q & ~halt & ~rst;

`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign;
    logic        do_fault;
    logic        fault_q;
    logic [31:0] faddr_q;

    assign misalign = ((size == 2'd1) & addr[0]) | (size[1] & (addr[1:0] != 2'd0));
    assign bad      = (is_load & is_store) | ((is_load | is_store) & misalign);
    assign lane     = addr[1:0];
    assign do_fault = acc & bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
            faddr_q <= '0;
        end else if (!halt) begin
            fault_q <= do_fault;
            if (do_fault) faddr_q <= addr;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = faddr_q;
`else
    // Without trapping, drop the address bits below the access size.
    assign bad        = is_load & is_store;
    assign lane       = (size == 2'd0) ? addr[1:0] :
                        (size == 2'd1) ? {addr[1], 1'b0} : 2'b00;
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

    assign do_load = acc & is_load & ~bad;
    assign do_wst  = acc & is_store & ~bad & ~is_sub;
    assign do_sst  = acc & is_store & ~bad & is_sub;

    assign rd_word = mem[widx];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        load_d = shifted;
        unique case (size)
            2'd0: load_d = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            2'd1: load_d = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_d = shifted;
        endcase
    end

    always_comb begin
        merged_d = hold_q;
        if (half_q) begin
            if (lane_q[1]) merged_d[31:16] = wdata_q[15:0];
            else           merged_d[15:0]  = wdata_q[15:0];
        end else begin
            unique case (lane_q)
                2'd0: merged_d[7:0]   = wdata_q[7:0];
                2'd1: merged_d[15:8]  = wdata_q[7:0];
                2'd2: merged_d[23:16] = wdata_q[7:0];
                default: merged_d[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            stall_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (!halt) begin
            rvalid_q <= do_load;
            if (do_load) rdata_q <= load_d;
            unique case (state_q)
                IDLE: begin
                    if (do_sst) begin
                        state_q <= RMW;
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; a reset edge during RMW simply skips the commit.
    always_ff @(posedge clk) begin
        if (!rst && !halt) begin
            if (do_wst) begin
                mem[widx] <= wdata;
            end else if (state_q == RMW) begin
                mem[widx_q] <= merged_d;
            end
            if (do_sst) begin
                widx_q  <= widx;
                lane_q  <= lane;
                half_q  <= size[0];
                wdata_q <= wdata;
                hold_q  <= rd_word;
            end
        end
    end

    assign stall       = stall_q;
    assign rdata_valid = rvalid_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Directed self-checking bench for dmem_port.
// Trap checks follow `DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] fault_addr;

    int vectors = 0;
    int miscompares = 0;

    dmem_port #(.ADDR_WIDTH(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .req_valid   (req_valid),
        .is_load     (is_load),
        .is_store    (is_store),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .fault       (fault),
        .fault_addr  (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic s,
                         input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        is_load   = l;
        is_store  = s;
        size      = sz;
        sign_ext  = se;
        addr      = a;
        wdata     = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        halt = 1'b0;
        idle();
        step();
        step();
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_rvalid", {31'b0, rdata_valid}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_faddr", fault_addr, 32'h0);
        rst = 1'b0;

        drive(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        step();
        chk("wst_nostall", {31'b0, stall}, 32'h0);
        chk("wst_norvalid", {31'b0, rdata_valid}, 32'h0);
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
        step();
        chk("wld_rvalid", {31'b0, rdata_valid}, 32'h1);
        chk("wld_data", rdata, 32'hDEADBEEF);

        drive(1, 0, 1, 2'd0, 0, 32'h12, 32'h0000005A);
        step();
        chk("bst_stall1", {31'b0, stall}, 32'h1);
        chk("bst_norvalid", {31'b0, rdata_valid}, 32'h0);
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
        step();
        chk("bst_stall0", {31'b0, stall}, 32'h0);
        chk("ld_in_stall_ignored", {31'b0, rdata_valid}, 32'h0);
        step();
        chk("ld_retry_rvalid", {31'b0, rdata_valid}, 32'h1);
        chk("ld_retry_merged", rdata, 32'hDE5ABEEF);

        drive(1, 1, 0, 2'd0, 1, 32'h13, 32'h0);
        step();
        chk("lb_sext", rdata, 32'hFFFFFFDE);
        drive(1, 1, 0, 2'd0, 0, 32'h12, 32'h0);
        step();
        chk("lbu", rdata, 32'h0000005A);
        drive(1, 1, 0, 2'd1, 0, 32'h10, 32'h0);
        step();
        chk("lhu", rdata, 32'h0000BEEF);
        drive(1, 1, 0, 2'd1, 1, 32'h12, 32'h0);
        step();
        chk("lh_sext_hi", rdata, 32'hFFFFDE5A);
        chk("lh_rvalid", {31'b0, rdata_valid}, 32'h1);
        idle();
        step();
        chk("rvalid_pulse_end", {31'b0, rdata_valid}, 32'h0);

        drive(1, 0, 1, 2'd2, 0, 32'h20, 32'hAAAAAAAA);
        step();
        drive(1, 0, 1, 2'd0, 0, 32'h21, 32'h00000077);
        step();
        chk("bst2_stall", {31'b0, stall}, 32'h1);
        drive(1, 0, 1, 2'd2, 0, 32'h20, 32'h55555555);
        step();
        idle();
        drive(1, 1, 0, 2'd2, 0, 32'h20, 32'h0);
        step();
        chk("st_in_stall_ignored", rdata, 32'hAAAA77AA);
        drive(1, 0, 1, 2'd1, 0, 32'h22, 32'h00001234);
        step();
        chk("hst_stall", {31'b0, stall}, 32'h1);
        idle();
        step();
        drive(1, 1, 0, 2'd2, 0, 32'h20, 32'h0);
        step();
        chk("hst_merged", rdata, 32'h123477AA);

        drive(1, 1, 0, 2'd1, 0, 32'h11, 32'h0);
        step();
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_faddr", fault_addr, 32'h11);
        chk("mis_norvalid", {31'b0, rdata_valid}, 32'h0);
`else
        chk("mis_nofault", {31'b0, fault}, 32'h0);
        chk("mis_rvalid", {31'b0, rdata_valid}, 32'h1);
        chk("mis_aligned_half", rdata, 32'h0000BEEF);
`endif
        drive(1, 1, 1, 2'd2, 0, 32'h10, 32'h0);
        step();
        chk("ldst_norvalid", {31'b0, rdata_valid}, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("ldst_fault", {31'b0, fault}, 32'h1);
`else
        chk("ldst_nofault", {31'b0, fault}, 32'h0);
`endif

        drive(1, 0, 1, 2'd0, 0, 32'h10, 32'h000000C3);
        step();
        idle();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_stall_held", {31'b0, stall}, 32'h1);
        end
        halt = 1'b0;
        step();
        chk("halt_release_stall0", {31'b0, stall}, 32'h0);
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
        step();
        chk("halt_rmw_commit", rdata, 32'hDE5ABEC3);
        idle();
        halt = 1'b1;
        step();
        step();
        chk("halt_rvalid_held", {31'b0, rdata_valid}, 32'h1);
        halt = 1'b0;
        step();
        chk("halt_rvalid_drop", {31'b0, rdata_valid}, 32'h0);

        drive(1, 0, 1, 2'd0, 0, 32'h10, 32'h00000000);
        step();
        chk("rst_rmw_stall1", {31'b0, stall}, 32'h1);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rmw_stall0", {31'b0, stall}, 32'h0);
        chk("rst_rmw_rdata0", rdata, 32'h0);
        drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
        step();
        chk("rst_rmw_untouched", rdata, 32'hDE5ABEC3);

        drive(1, 1, 0, 2'd2, 0, 32'h00010010, 32'h0);
        step();
        chk("addr_wrap", rdata, 32'hDE5ABEC3);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
